// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART types and constants: receiver state encoding,
//             oversampling ratio, sample-point indices and a vote helper.
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);

  // Tick indices within one bit period; ticks 7..9 straddle the bit centre.
  localparam logic [SAMPLE_W-1:0] SAMPLE_LO  = SAMPLE_W'(7);
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID = SAMPLE_W'(8);
  localparam logic [SAMPLE_W-1:0] SAMPLE_HI  = SAMPLE_W'(9);
  localparam logic [SAMPLE_W-1:0] BIT_END    = SAMPLE_W'(15);

  // Two-out-of-three majority vote.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Oversample tick generator. Counts 0..divisor_i while enabled and
//             pulses tick_o on the terminal count; held at zero when disabled.
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == divisor_i);

  // Next count: clear when idle or at terminal count, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == divisor_i)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 16x-oversampling UART receiver feeding the RX FIFO. Majority
//             votes each bit, checks optional parity and the stop bit, and
//             emits one-cycle PUSH / FRAME_ERR / PARITY_ERR / OVERRUN pulses.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [DIV_WIDTH-1:0]  DIVISOR,
  input  logic                  RXD,
  input  logic                  PARITY_EN,
  input  logic                  PARITY_ODD,
  input  logic                  FULL,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  PUSH,
  output logic                  FRAME_ERR,
  output logic                  PARITY_ERR,
  output logic                  OVERRUN,
  output logic                  BUSY
);

  localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e             state_q, state_d;
  logic [1:0]              sync_q;
  logic [SAMPLE_W-1:0]     scnt_q, scnt_d;
  logic                    vlo_q, vlo_d, vmid_q, vmid_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    perr_q, perr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    push_q, push_d, ferr_q, ferr_d;
  logic                    perr_out_q, perr_out_d, ovr_q, ovr_d;

  logic                    rxd_s, tick, vote, at_hi, at_end;
  logic [SAMPLE_W-1:0]     scnt_next;

  assign rxd_s     = sync_q[1];
  assign scnt_next = scnt_q + 1'b1;
  assign vote      = majority3(vlo_q, vmid_q, rxd_s);
  assign at_hi     = tick && (scnt_next == SAMPLE_HI);
  assign at_end    = tick && (scnt_next == BIT_END);

  assign DATA_OUT   = data_q;
  assign PUSH       = push_q;
  assign FRAME_ERR  = ferr_q;
  assign PARITY_ERR = perr_out_q;
  assign OVERRUN    = ovr_q;
  assign BUSY       = (state_q != IDLE);

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_i     (CLK),
    .rst_ni    (RESETn),
    .en_i      (state_q != IDLE),
    .divisor_i (DIVISOR),
    .tick_o    (tick)
  );

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RXD};
    end
  end

  // Next-state, sampling, shifting and pulse generation.
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    vlo_d      = vlo_q;
    vmid_d     = vmid_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    perr_d     = perr_q;
    data_d     = data_q;
    push_d     = 1'b0;
    ferr_d     = 1'b0;
    perr_out_d = 1'b0;
    ovr_d      = 1'b0;

    if (tick) begin
      scnt_d = scnt_next;
      if (scnt_next == SAMPLE_LO)  vlo_d  = rxd_s;
      if (scnt_next == SAMPLE_MID) vmid_d = rxd_s;
    end

    case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (at_hi && vote) begin
          state_d = IDLE;
        end else if (at_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (at_hi) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        if (at_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_hi)  perr_d  = vote ^ (^shift_q) ^ PARITY_ODD;
        if (at_end) state_d = STOP;
      end
      STOP: begin
        // Return to IDLE at mid-stop so a back-to-back start edge is seen.
        if (at_hi) begin
          state_d = IDLE;
          if (!vote) begin
            ferr_d = 1'b1;
          end else if (FULL) begin
            ovr_d = 1'b1;
          end else begin
            push_d     = 1'b1;
            data_d     = shift_q;
            perr_out_d = perr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) scnt_d = '0;
  end

  // Receiver state and registered outputs.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      scnt_q     <= '0;
      vlo_q      <= 1'b1;
      vmid_q     <= 1'b1;
      shift_q    <= '0;
      idx_q      <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      push_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      vlo_q      <= vlo_d;
      vmid_q     <= vmid_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      push_q     <= push_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule
`default_nettype wire
